// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter
//   Shares one single-ported unified RAM between the instruction-fetch
//   requester (I port) and the load/store requester (D port). At most one
//   memory transaction is in flight; the controller walks IDLE -> ISSUE -> WAIT.
//
//   Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//     undefined : fixed priority, D beats I when both request in IDLE.
//     defined   : when both request, the port that did not own the previous
//                 transaction wins, so I and D alternate under contention.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   i_req, i_addr       fetch request (held until i_gnt)
//   i_gnt               fetch request accepted by memory (1-cycle pulse)
//   i_rvalid, i_rdata   fetch data return (1-cycle pulse)
//   d_req, d_we, d_be,
//   d_addr, d_wdata     load/store request (held until d_gnt)
//   d_gnt               data request accepted (1-cycle pulse)
//   d_rvalid, d_rdata   load data / store acknowledge (1-cycle pulse)
//   m_req, m_we, m_be,
//   m_addr, m_wdata     memory request fields
//   m_gnt               memory accepts m_req this cycle
//   m_rvalid, m_rdata   memory response, one per accepted request
//   busy                a transaction is being issued, awaited or returned
module rv_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Owner of the current/most recent transaction (1 = D, 0 = I). It only
  // changes at arbitration, so it also serves as the last-owner record that
  // round-robin selection looks at.
  logic own_d;

  logic arb_take;   // IDLE with a request: start a transaction this cycle
  logic arb_pick_d; // winner of this cycle's arbitration is D

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    arb_take   = 1'b0;
    arb_pick_d = 1'b0;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    // The return cycle still belongs to the transaction even though the
    // controller is already back in IDLE arbitrating the next one.
    busy       = (state != IDLE) | i_rvalid | d_rvalid;
    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          arb_take  = 1'b1;
          state_nxt = ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (i_req && d_req) begin
            arb_pick_d = ~own_d;
          end else begin
            arb_pick_d = d_req;
          end
`else
          arb_pick_d = d_req;
`endif
        end
      end
      ISSUE: begin
        i_gnt = m_gnt & ~own_d;
        d_gnt = m_gnt & own_d;
        if (m_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request fields, owner and response registers. Everything is cleared on
  // reset so an aborted transaction leaves no trace on any output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_d    <= 1'b1;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= 4'b0000;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (arb_take) begin
        own_d <= arb_pick_d;
        m_req <= 1'b1;
        if (arb_pick_d) begin
          m_we    <= d_we;
          m_be    <= d_be;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
        end else begin
          // Fetches are full-word reads; write data is parked at zero.
          m_we    <= 1'b0;
          m_be    <= 4'b1111;
          m_addr  <= i_addr;
          m_wdata <= '0;
        end
      end
      if ((state == ISSUE) && m_gnt) begin
        m_req <= 1'b0;
      end
      if ((state == WAIT) && m_rvalid) begin
        if (own_d) begin
          d_rvalid <= 1'b1;
          d_rdata  <= m_rdata;
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Testbench for rv_mem_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_rv_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_gnt, m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          busy;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: is a transaction open, has memory accepted it,
  // who owns it, what was latched, and which response returns this cycle.
  bit            mo_open, mo_accepted, mo_own_d, mo_ret_i, mo_ret_d;
  logic          mo_we;
  logic [3:0]    mo_be;
  logic [AW-1:0] mo_addr;
  logic [DW-1:0] mo_wdata, mo_rd_i, mo_rd_d;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    mo_open = 0; mo_accepted = 0; mo_own_d = 1; mo_ret_i = 0; mo_ret_d = 0;
    mo_we = 0; mo_be = 4'h0; mo_addr = '0; mo_wdata = '0; mo_rd_i = '0; mo_rd_d = '0;
  endtask

  // Winner when a new transaction starts; mo_own_d still names the previous owner.
  function automatic bit pick_d();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) return !mo_own_d;
`endif
    return d_req;
  endfunction

  function automatic bit exp_mreq();
    return mo_open && !mo_accepted;
  endfunction

  task automatic compare_model();
    chk("m_req",    m_req,    exp_mreq());
    chk("m_we",     m_we,     mo_we);
    chk("m_be",     m_be,     mo_be);
    chk("m_addr",   m_addr,   mo_addr);
    chk("m_wdata",  m_wdata,  mo_wdata);
    chk("i_gnt",    i_gnt,    exp_mreq() && m_gnt && !mo_own_d);
    chk("d_gnt",    d_gnt,    exp_mreq() && m_gnt && mo_own_d);
    chk("i_rvalid", i_rvalid, mo_ret_i);
    chk("d_rvalid", d_rvalid, mo_ret_d);
    chk("i_rdata",  i_rdata,  mo_rd_i);
    chk("d_rdata",  d_rdata,  mo_rd_d);
    chk("busy",     busy,     mo_open || mo_ret_i || mo_ret_d);
  endtask

  task automatic model_update();
    bit w;
    if (reset) return;
    mo_ret_i = 0;
    mo_ret_d = 0;
    if (!mo_open) begin
      if (i_req || d_req) begin
        w = pick_d();
        mo_own_d = w; mo_open = 1; mo_accepted = 0;
        if (w) begin
          mo_we = d_we; mo_be = d_be; mo_addr = d_addr; mo_wdata = d_wdata;
        end else begin
          mo_we = 0; mo_be = 4'hF; mo_addr = i_addr; mo_wdata = '0;
        end
      end
    end else if (!mo_accepted) begin
      if (m_gnt) mo_accepted = 1;
    end else if (m_rvalid) begin
      mo_open = 0;
      if (mo_own_d) begin mo_ret_d = 1; mo_rd_d = m_rdata; end
      else begin mo_ret_i = 1; mo_rd_i = m_rdata; end
    end
  endtask

  // Inputs are set just after a rising edge; sample() checks at the falling
  // edge, advance() applies the model for the coming edge and moves past it.
  task automatic sample();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {m_req, m_we, m_be, i_gnt, d_gnt, i_rvalid, d_rvalid, busy}, 64'd0);
    chk({nm, "_addr"}, m_addr, 64'd0);
    chk({nm, "_wdata"}, m_wdata, 64'd0);
    chk({nm, "_irdata"}, i_rdata, 64'd0);
    chk({nm, "_drdata"}, d_rdata, 64'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    #1;
    model_reset();
    chk_all_zero("rst");
    sample();
    advance();
    reset = 0;
  endtask

  initial begin
    bit [2:0] order;
    bit [2:0] want_order;
    int ngnt, d_gnt_cnt;
    bit i_noise, i_hold, d_hold, gi, gd;

    reset = 1;
    idle_inputs();
    model_reset();
    #1;
    do_reset();

    // Single fetch, zero-wait memory.
    i_req = 1; i_addr = 32'h10;
    sample(); chk("f0_busy", busy, 0); advance();
    m_gnt = 1;
    sample();
    chk("f1_mreq", m_req, 1); chk("f1_addr", m_addr, 32'h10); chk("f1_we", m_we, 0);
    chk("f1_be", m_be, 4'hF); chk("f1_igntd", i_gnt, 1); chk("f1_busy", busy, 1);
    advance();
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h93;
    sample(); chk("f2_busy", busy, 1); chk("f2_irv", i_rvalid, 0); advance();
    m_rvalid = 0; m_rdata = '0;
    sample();
    chk("f3_irv", i_rvalid, 1); chk("f3_irdata", i_rdata, 32'h93); chk("f3_busy", busy, 1);
    advance();
    sample(); chk("f4_idle", {i_rvalid, busy}, 0); advance();

    // Store with three wait states before m_gnt, response two cycles later.
    do_reset();
    d_req = 1; d_we = 1; d_be = 4'b0010; d_addr = 32'h104; d_wdata = 32'hAB00;
    d_gnt_cnt = 0; i_noise = 0;
    sample(); advance();
    for (int c = 1; c <= 7; c++) begin
      m_gnt    = (c == 4);
      m_rvalid = (c == 6);
      m_rdata  = (c == 6) ? 32'h5555_AAAA : '0;
      if (c == 5) d_req = 0;
      sample();
      if (c <= 4) begin
        chk("st_mreq", m_req, 1); chk("st_addr", m_addr, 32'h104); chk("st_we", m_we, 1);
        chk("st_be", m_be, 4'b0010); chk("st_wdata", m_wdata, 32'hAB00);
      end
      if (c == 7) chk("st_drv", d_rvalid, 1);
      if (d_gnt) d_gnt_cnt++;
      if (i_gnt || i_rvalid || (i_rdata != 0)) i_noise = 1;
      advance();
    end
    chk("st_dgnt_cnt", d_gnt_cnt, 1);
    chk("st_i_quiet", i_noise, 0);

    // Contention: both requesters held high, zero-wait memory.
    do_reset();
    i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h800;
    ngnt = 0; order = 3'b000;
    for (int c = 0; c < 40 && ngnt < 3; c++) begin
      m_gnt    = exp_mreq();
      m_rvalid = mo_open && mo_accepted;
      m_rdata  = $urandom;
      sample();
      if (i_gnt || d_gnt) begin
        order[2 - ngnt] = d_gnt;
        ngnt++;
      end
      advance();
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    want_order = 3'b010;
`else
    want_order = 3'b111;
`endif
    chk("cont_ngnt", ngnt, 3);
    chk("cont_order", order, want_order);

    // Reset during WAIT of a D load: response arriving afterwards is dropped.
    do_reset();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
    sample(); advance();
    m_gnt = 1;
    sample(); chk("rw_dgnt", d_gnt, 1); advance();
    d_req = 0; m_gnt = 0;
    sample(); chk("rw_busy_wait", busy, 1);
    reset = 1;
    #1;
    model_reset();
    chk_all_zero("rw");
    advance();
    reset = 0; m_rvalid = 1; m_rdata = 32'hDEAD;
    sample(); chk("rw_drv0", d_rvalid, 0); advance();
    m_rvalid = 0; m_rdata = '0;
    sample(); chk("rw_after", {d_rvalid, busy}, 0); chk("rw_drdata", d_rdata, 0); advance();

    // Spurious m_rvalid while idle.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      m_rvalid = (c < 3); m_rdata = $urandom;
      sample(); chk("spur_quiet", {i_rvalid, d_rvalid, busy}, 0); advance();
    end

    // Randomized traffic.
    do_reset();
    i_hold = 0; d_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        i_hold = 0; d_hold = 0;
      end
      if (!i_hold && $urandom_range(0, 1) == 1) begin
        i_hold = 1; i_addr = $urandom;
      end
      if (!d_hold && $urandom_range(0, 2) == 0) begin
        d_hold = 1; d_we = $urandom_range(0, 1); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      i_req = i_hold; d_req = d_hold;
      m_rdata = $urandom;
      if (exp_mreq()) m_gnt = ($urandom_range(0, 1) == 1);
      else            m_gnt = ($urandom_range(0, 3) == 0);
      if (mo_open && mo_accepted) m_rvalid = ($urandom_range(0, 1) == 1);
      else if (!mo_open)          m_rvalid = ($urandom_range(0, 6) == 0);
      else                        m_rvalid = 0;
      gi = exp_mreq() && m_gnt && !mo_own_d;
      gd = exp_mreq() && m_gnt && mo_own_d;
      sample();
      advance();
      if (gi) i_hold = 0;
      if (gd) d_hold = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
